// File: rtl/fetch_pc_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl_if
// Description : Bundle of fetch-sequencer signals shared by the front end:
//               decode backpressure, execute redirect, cache response,
//               the next fetch address and the presented bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_pc_ctrl_if;
  logic        i_stall;
  logic        i_redirect_vld;
  logic [31:0] i_redirect_pc;
  logic        i_cache_vld;
  logic [31:0] o_fetch_pc;
  logic [31:0] o_pc;
  logic [1:0]  o_instr_vld;
  logic        o_busy;

  // Environment side: drives control inputs, observes the sequencer.
  modport master (
    output i_stall, i_redirect_vld, i_redirect_pc, i_cache_vld,
    input  o_fetch_pc, o_pc, o_instr_vld, o_busy
  );

  // Sequencer side.
  modport slave (
    input  i_stall, i_redirect_vld, i_redirect_pc, i_cache_vld,
    output o_fetch_pc, o_pc, o_instr_vld, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Next-PC sequencer for the 2-issue front end. Issues one
//               cache request per cycle, presents the returned bundle to
//               decode, replays on stall, re-requests on miss and kills the
//               in-flight bundle on redirect.
// Options     : FETCH_ALIGN_EN - when defined, a bundle at a PC with bit 2
//               set presents only slot 0 and advances by 4 so the following
//               request is 8-byte aligned.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  fetch_pc_ctrl_if.slave        bus
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_MISS = 2'd2;

  logic [1:0]  state_q;
  logic [1:0]  state_d;
  logic [31:0] r_req_pc_q;
  logic [31:0] r_req_pc_d;
  logic        r_inflight_q;

  logic        w_present;
  logic [1:0]  w_mask;
  logic [31:0] w_step;
  logic [31:0] w_redirect_pc;
  logic [1:0]  w_unused_rpc_lo;

  // The low two redirect bits are architecturally ignored.
  assign w_redirect_pc   = {bus.i_redirect_pc[31:2], 2'b00};
  assign w_unused_rpc_lo = bus.i_redirect_pc[1:0];

  // A bundle is only visible to decode if its request is outstanding,
  // the cache returned it, and execute is not redirecting this cycle.
  assign w_present = r_inflight_q & bus.i_cache_vld & ~bus.i_redirect_vld;

`ifdef FETCH_ALIGN_EN
  // Odd-word PC: only slot 0 is in this 8-byte block; realign afterwards.
  assign w_mask = r_req_pc_q[2] ? 2'b01 : 2'b11;
  assign w_step = r_req_pc_q[2] ? 32'd4 : 32'd8;
`else
  assign w_mask = 2'b11;
  assign w_step = 32'd8;
`endif

  // State and request-PC registers; every non-reset edge launches a request.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_BOOT;
      r_req_pc_q   <= RESET_PC;
      r_inflight_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      r_req_pc_q   <= r_req_pc_d;
      r_inflight_q <= 1'b1;
    end
  end

  // Next-PC mux and next state: redirect > miss > stall replay > advance.
  always_comb begin
    state_d    = state_q;
    r_req_pc_d = r_req_pc_q;
    if (i_rst) begin
      state_d    = S_BOOT;
      r_req_pc_d = RESET_PC;
    end else if (state_q == S_BOOT) begin
      state_d    = S_RUN;
      r_req_pc_d = RESET_PC;
    end else if (bus.i_redirect_vld) begin
      state_d    = S_RUN;
      r_req_pc_d = w_redirect_pc;
    end else if (r_inflight_q && !bus.i_cache_vld) begin
      state_d    = S_MISS;
      r_req_pc_d = r_req_pc_q;
    end else if (w_present && bus.i_stall) begin
      state_d    = S_RUN;
      r_req_pc_d = r_req_pc_q;
    end else if (w_present) begin
      state_d    = S_RUN;
      r_req_pc_d = r_req_pc_q + w_step;
    end else begin
      state_d    = S_RUN;
      r_req_pc_d = r_req_pc_q;
    end
  end

  // Outputs toward the cache and decode.
  always_comb begin
    bus.o_fetch_pc  = r_req_pc_d;
    bus.o_pc        = r_req_pc_q;
    bus.o_busy      = (state_q == S_MISS);
    bus.o_instr_vld = 2'b00;
    if (!i_rst && w_present) begin
      bus.o_instr_vld = w_mask;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_ctrl
// Description : Self-checking bench for fetch_pc_ctrl: directed scenarios
//               followed by randomized traffic against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  fetch_pc_ctrl_if u_if ();

  fetch_pc_ctrl #(.RESET_PC(C_RESET_PC)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model of what the sequencer has outstanding.
  bit          m_known;
  bit          m_boot;
  bit          m_pending;
  bit          m_miss;
  logic [31:0] m_req;

  // Values observed at the most recent step, for directed checks.
  logic [31:0] obs_fetch;
  logic [31:0] obs_pc;
  logic [1:0]  obs_mask;
  logic        obs_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, compare against the model, then advance it.
  task automatic step(input bit r, input bit st, input bit rv,
                      input logic [31:0] rpc, input bit cv);
    logic [31:0] e_fetch;
    logic [1:0]  e_mask;
    logic [31:0] e_step;
    bit          present;
    rst                = r;
    u_if.i_stall       = st;
    u_if.i_redirect_vld = rv;
    u_if.i_redirect_pc = rpc;
    u_if.i_cache_vld   = cv;
    #1;
`ifdef FETCH_ALIGN_EN
    e_mask = m_req[2] ? 2'b01 : 2'b11;
    e_step = m_req[2] ? 32'd4 : 32'd8;
`else
    e_mask = 2'b11;
    e_step = 32'd8;
`endif
    present = m_pending && cv && !rv && !m_boot;
    if (r || m_boot) begin
      e_fetch = C_RESET_PC;
      present = 1'b0;
    end else if (rv) begin
      e_fetch = rpc & 32'hFFFF_FFFC;
    end else if (m_pending && !cv) begin
      e_fetch = m_req;
    end else if (present && st) begin
      e_fetch = m_req;
    end else if (present) begin
      e_fetch = m_req + e_step;
    end else begin
      e_fetch = m_req;
    end
    if (!present) e_mask = 2'b00;

    obs_fetch = u_if.o_fetch_pc;
    obs_pc    = u_if.o_pc;
    obs_mask  = u_if.o_instr_vld;
    obs_busy  = u_if.o_busy;
    chk("fetch_pc", obs_fetch, e_fetch);
    chk("instr_vld", {30'd0, obs_mask}, {30'd0, e_mask});
    if (m_known) begin
      chk("pc", obs_pc, m_req);
      chk("busy", {31'd0, obs_busy}, {31'd0, m_miss});
    end

    @(posedge clk);
    if (r) begin
      m_known   = 1'b1;
      m_boot    = 1'b1;
      m_pending = 1'b0;
      m_miss    = 1'b0;
      m_req     = C_RESET_PC;
    end else begin
      m_miss    = !m_boot && !rv && m_pending && !cv;
      m_req     = e_fetch;
      m_pending = 1'b1;
      m_boot    = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    m_known   = 1'b0;
    m_boot    = 1'b1;
    m_pending = 1'b0;
    m_miss    = 1'b0;
    m_req     = C_RESET_PC;

    // Reset, then reset-state outputs.
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 1);
    chk("rst_pc", obs_pc, 32'h0);
    chk("rst_busy", {31'd0, obs_busy}, 32'd0);

    // Boot: first request at RESET_PC, bundles start two cycles after release.
    step(0, 0, 0, 32'h0, 1);
    chk("boot_fetch0", obs_fetch, 32'h0);
    chk("boot_mask0", {30'd0, obs_mask}, 32'd0);
    step(0, 0, 0, 32'h0, 1);
    chk("boot_pc0", obs_pc, 32'h0);
    chk("boot_mask1", {30'd0, obs_mask}, 32'd3);
    chk("boot_fetch8", obs_fetch, 32'h8);
    step(0, 0, 0, 32'h0, 1);
    chk("boot_pc8", obs_pc, 32'h8);
    chk("boot_fetch16", obs_fetch, 32'h10);

    // Stall three cycles on 0x10, then accept and move to 0x18.
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 32'h0, 1);
      chk("stall_pc", obs_pc, 32'h10);
      chk("stall_mask", {30'd0, obs_mask}, 32'd3);
      chk("stall_fetch", obs_fetch, 32'h10);
    end
    step(0, 0, 0, 32'h0, 1);
    chk("stall_rel_pc", obs_pc, 32'h10);
    chk("stall_rel_fetch", obs_fetch, 32'h18);
    step(0, 0, 0, 32'h0, 1);
    chk("post_stall_pc", obs_pc, 32'h18);

    // Miss for two cycles at 0x20.
    step(0, 0, 0, 32'h0, 0);
    chk("miss_mask", {30'd0, obs_mask}, 32'd0);
    chk("miss_fetch", obs_fetch, 32'h20);
    step(0, 1, 0, 32'h0, 0);
    chk("miss_busy", {31'd0, obs_busy}, 32'd1);
    chk("miss_fetch2", obs_fetch, 32'h20);
    step(0, 0, 0, 32'h0, 1);
    chk("miss_ret_pc", obs_pc, 32'h20);
    chk("miss_ret_mask", {30'd0, obs_mask}, 32'd3);
    chk("miss_ret_fetch", obs_fetch, 32'h28);

    // Redirect coinciding with stall.
    step(0, 1, 1, 32'h0000_1003, 1);
    chk("redir_mask", {30'd0, obs_mask}, 32'd0);
    chk("redir_fetch", obs_fetch, 32'h1000);
    step(0, 0, 0, 32'h0, 1);
    chk("redir_pc", obs_pc, 32'h1000);
    chk("redir_busy", {31'd0, obs_busy}, 32'd0);

    // Wrap-around past the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFF8, 1);
    step(0, 0, 0, 32'h0, 1);
    chk("wrap_pc", obs_pc, 32'hFFFF_FFF8);
    chk("wrap_fetch", obs_fetch, 32'h0);

    // Odd-word redirect target.
    step(0, 0, 1, 32'h0000_0104, 1);
    step(0, 0, 0, 32'h0, 1);
    chk("odd_pc", obs_pc, 32'h104);
`ifdef FETCH_ALIGN_EN
    chk("odd_mask", {30'd0, obs_mask}, 32'd1);
    chk("odd_fetch", obs_fetch, 32'h108);
    step(0, 0, 0, 32'h0, 1);
    chk("odd_next_pc", obs_pc, 32'h108);
    chk("odd_next_mask", {30'd0, obs_mask}, 32'd3);
`else
    chk("odd_mask", {30'd0, obs_mask}, 32'd3);
    chk("odd_fetch", obs_fetch, 32'h10C);
    step(0, 0, 0, 32'h0, 1);
    chk("odd_next_pc", obs_pc, 32'h10C);
`endif

    // Reset in the middle of a miss discards the request.
    step(0, 0, 0, 32'h0, 0);
    step(0, 0, 0, 32'h0, 0);
    step(1, 0, 0, 32'h0, 1);
    step(0, 0, 0, 32'h0, 1);
    chk("rst_miss_mask", {30'd0, obs_mask}, 32'd0);
    chk("rst_miss_busy", {31'd0, obs_busy}, 32'd0);
    step(0, 0, 0, 32'h0, 1);
    chk("rst_miss_pc", obs_pc, 32'h0);
    chk("rst_miss_vld", {30'd0, obs_mask}, 32'd3);

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      step(($urandom % 40) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
           $urandom, ($urandom % 6) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
